demux_gate_sweeper: RTL and testbench

Parametrised successor to the two-input demux-built universal gates. It implements an N_IN-input logic gate as a 1:2^N_IN demultiplexer followed by a per-mode OR mask, and selects the gate function at run time. A sequencer sweeps every input combination, streams each truth-table row over a valid/ready handshake, and captures the full table in a register. It sits beside the gate library as a self-characterising gate engine for benches and on-chip checks.

---
 rtl/demux_gate_sweeper.sv | 139 +++++++++++++
 tb/tb_demux_gate_sweeper.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/demux_gate_sweeper.sv
// Run-time selectable N_IN-input gate built from a 1:2^N_IN demux plus an OR mask,
// with a sequencer that streams and captures the full truth table.
module demux_gate_sweeper #(
   parameter int N_IN = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [2:0]             mode,
   output logic                   busy,
   output logic                   row_valid,
   input  logic                   row_ready,
   output logic [N_IN-1:0]        row_in,
   output logic                   row_out,
   output logic [(1<<N_IN)-1:0]   table_out,
   output logic                   done,
   output logic                   err
);

   localparam int ROWS = 1 << N_IN;
   localparam logic [N_IN:0] LAST_ROW = (N_IN+1)'(ROWS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [N_IN:0]     cnt_q, cnt_d;
   logic [2:0]        mode_q, mode_d;
   logic [ROWS-1:0]   table_q, table_d;
   logic              err_q, err_d;
   logic [ROWS-1:0]   demux_s;
   logic [ROWS-1:0]   mask_s;
   logic              row_out_s;

   function automatic logic odd_parity(input logic [N_IN-1:0] v);
      return ^v;
   endfunction

   function automatic logic mask_bit(input logic [2:0] m, input logic [N_IN-1:0] i);
      logic b;
      case (m)
         3'd0:    b = (i == {N_IN{1'b1}});
         3'd1:    b = (i != {N_IN{1'b0}});
         3'd2:    b = (i != {N_IN{1'b1}});
         3'd3:    b = (i == {N_IN{1'b0}});
         3'd4:    b = odd_parity(i);
         3'd5:    b = ~odd_parity(i);
         default: b = 1'b0;
      endcase
      return b;
   endfunction

   // Gate core: one-hot demux line for the current row, masked by the latched mode.
   always_comb begin
      demux_s = {ROWS{1'b0}};
      demux_s[cnt_q[N_IN-1:0]] = 1'b1;
      for (int i = 0; i < ROWS; i++) begin
         mask_s[i] = mask_bit(mode_q, i[N_IN-1:0]);
      end
      row_out_s = (state_q == RUN) && (|(demux_s & mask_s));
   end

   // Sequencer next-state: sweep rows, capture the table, flag illegal starts.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      table_d = table_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (mode <= 3'd5) begin
                  mode_d  = mode;
                  cnt_d   = {(N_IN+1){1'b0}};
                  state_d = RUN;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (row_ready) begin
               // The old table survives until the first row of a new sweep lands.
               if (cnt_q == {(N_IN+1){1'b0}}) begin
                  table_d = {ROWS{1'b0}};
               end else begin
                  table_d = table_q;
               end
               table_d[cnt_q[N_IN-1:0]] = row_out_s;
               if (cnt_q == LAST_ROW) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + {{N_IN{1'b0}}, 1'b1};
               end
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous reset taking priority over any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= {(N_IN+1){1'b0}};
         mode_q  <= 3'd0;
         table_q <= {ROWS{1'b0}};
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         table_q <= table_d;
         err_q   <= err_d;
      end
   end

   assign busy      = (state_q == RUN);
   assign row_valid = (state_q == RUN);
   assign row_in    = cnt_q[N_IN-1:0];
   assign row_out   = row_out_s;
   assign table_out = table_q;
   assign done      = (state_q == DONE);
   assign err       = err_q;

endmodule

// File: tb/tb_demux_gate_sweeper.sv
// Directed bench for demux_gate_sweeper: two instances (N_IN=2 and N_IN=3) share
// clock/reset; hand-computed truth tables are checked row by row and at done.
module tb_demux_gate_sweeper;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_s = 1'b0;
   logic [2:0] mode_s = 3'd0;
   logic       ready_s = 1'b1;
   logic       sel3 = 1'b0;

   logic       start2, busy2, valid2, row_out2, done2, err2;
   logic [1:0] row_in2;
   logic [3:0] table2;
   logic       start3, busy3, valid3, row_out3, done3, err3;
   logic [2:0] row_in3;
   logic [7:0] table3;

   logic       busy_m, valid_m, row_out_m, done_m, err_m;
   logic [2:0] row_in_m;
   logic [7:0] table_m;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   assign start2 = start_s & ~sel3;
   assign start3 = start_s &  sel3;

   demux_gate_sweeper #(.N_IN(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .mode(mode_s), .busy(busy2),
      .row_valid(valid2), .row_ready(ready_s), .row_in(row_in2), .row_out(row_out2),
      .table_out(table2), .done(done2), .err(err2)
   );

   demux_gate_sweeper #(.N_IN(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .mode(mode_s), .busy(busy3),
      .row_valid(valid3), .row_ready(ready_s), .row_in(row_in3), .row_out(row_out3),
      .table_out(table3), .done(done3), .err(err3)
   );

   assign busy_m    = sel3 ? busy3    : busy2;
   assign valid_m   = sel3 ? valid3   : valid2;
   assign row_out_m = sel3 ? row_out3 : row_out2;
   assign done_m    = sel3 ? done3    : done2;
   assign err_m     = sel3 ? err3     : err2;
   assign row_in_m  = sel3 ? row_in3  : {1'b0, row_in2};
   assign table_m   = sel3 ? table3   : {4'h0, table2};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " busy"},      busy_m,    32'd0);
      check({tag, " row_valid"}, valid_m,   32'd0);
      check({tag, " row_in"},    row_in_m,  32'd0);
      check({tag, " row_out"},   row_out_m, 32'd0);
      check({tag, " table"},     table_m,   32'd0);
      check({tag, " done"},      done_m,    32'd0);
      check({tag, " err"},       err_m,     32'd0);
   endtask

   task automatic run_sweep(input string tag, input logic s3, input logic [2:0] m,
                            input logic [7:0] exp_tab, input logic [7:0] prev_tab,
                            input int stall_row, input int stall_n, input logic poke);
      int rows;
      int exp_row;
      int stalls;
      int cyc;
      rows    = s3 ? 8 : 4;
      exp_row = 0;
      stalls  = 0;
      sel3    = s3;
      mode_s  = m;
      ready_s = 1'b1;
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      cyc = 1;
      check({tag, " busy@start"},  busy_m,  32'd1);
      check({tag, " table held"},  table_m, {24'd0, prev_tab});
      while (!done_m && cyc < 64) begin
         check({tag, " row_valid"}, valid_m,   32'd1);
         check({tag, " row_in"},    row_in_m,  exp_row);
         check({tag, " row_out"},   row_out_m, {31'd0, exp_tab[exp_row]});
         if (exp_row == stall_row && stalls < stall_n) begin
            ready_s = 1'b0;
            stalls++;
         end else begin
            ready_s = 1'b1;
         end
         if (poke && cyc == 2) begin
            start_s = 1'b1;
            mode_s  = 3'd7;
         end else begin
            start_s = 1'b0;
         end
         tick();
         if (ready_s) exp_row++;
         cyc++;
      end
      start_s = 1'b0;
      ready_s = 1'b1;
      check({tag, " done"},   done_m,  32'd1);
      check({tag, " busy@done"}, busy_m, 32'd0);
      check({tag, " cycles"}, cyc,     rows + 1 + stall_n);
      check({tag, " table"},  table_m, {24'd0, exp_tab});
      check({tag, " no err"}, err_m,   32'd0);
      tick();
      check({tag, " done pulse"}, done_m, 32'd0);
      check({tag, " idle busy"},  busy_m, 32'd0);
   endtask

   initial begin
      int guard;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      sel3 = 1'b0;
      check_all_zero("reset n2");
      sel3 = 1'b1;
      check_all_zero("reset n3");

      run_sweep("nor2",  1'b0, 3'd3, 8'h01, 8'h00, -1, 0, 1'b0);
      run_sweep("nand2", 1'b0, 3'd2, 8'h07, 8'h01, -1, 0, 1'b0);
      run_sweep("and2",  1'b0, 3'd0, 8'h08, 8'h07, -1, 0, 1'b0);
      run_sweep("or2bp", 1'b0, 3'd1, 8'h0E, 8'h08,  1, 3, 1'b0);

      // Illegal mode: err pulse only, nothing else moves.
      sel3 = 1'b0;
      mode_s = 3'd7;
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      check("illegal err",   err_m,   32'd1);
      check("illegal busy",  busy_m,  32'd0);
      check("illegal table", table_m, 32'h0E);
      tick();
      check("illegal err pulse", err_m,  32'd0);
      check("illegal idle",      busy_m, 32'd0);

      run_sweep("xor3",  1'b1, 3'd4, 8'h96, 8'h00, -1, 0, 1'b0);
      run_sweep("xnor3", 1'b1, 3'd5, 8'h69, 8'h96, -1, 0, 1'b1);

      // Reset lands together with the row-2 handshake.
      sel3 = 1'b0;
      mode_s = 3'd3;
      ready_s = 1'b1;
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      guard = 0;
      while (row_in_m != 3'd2 && guard < 16) begin
         tick();
         guard++;
      end
      check("rst reached row2", row_in_m, 32'd2);
      rst = 1'b1;
      tick();
      check_all_zero("mid reset");
      rst = 1'b0;
      tick();
      check("post reset idle", busy_m, 32'd0);
      run_sweep("nor2 again", 1'b0, 3'd3, 8'h01, 8'h00, -1, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
